// File: rtl/quanet_frame_sched.sv
// quanet_frame_sched: burst frame scheduler driving TX, RX switch and capture windows
module quanet_frame_sched #(
  parameter int CNT_W = 24,
  parameter int IDX_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             stop,
  input  logic             ext_trig,
  input  logic             cfg_use_trig,
  input  logic [CNT_W-1:0] cfg_frame_len,
  input  logic [IDX_W-1:0] cfg_num_frames,
  input  logic [CNT_W-1:0] cfg_tx_len,
  input  logic [CNT_W-1:0] cfg_sw_on,
  input  logic [CNT_W-1:0] cfg_sw_off,
  input  logic [CNT_W-1:0] cfg_cap_dly,
  input  logic [CNT_W-1:0] cfg_cap_len,
  input  logic             cap_ready,
  output logic             tx_en,
  output logic             rxq_sw_ctl,
  output logic             cap_en,
  output logic             frame_start,
  output logic             busy,
  output logic             done,
  output logic             cap_ovf,
  output logic [IDX_W-1:0] frame_idx
);
  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] fc_q, fc_d, len_q, len_d, txl_q, txl_d;
  logic [CNT_W-1:0] swon_q, swon_d, swoff_q, swoff_d, cdly_q, cdly_d, clen_q, clen_d;
  logic [IDX_W-1:0] idx_q, idx_d, nfr_q, nfr_d;
  logic cap_ok_q, cap_ok_d, stop_pend_q, stop_pend_d, trig_d_q, cap_ovf_q, cap_ovf_d;
  logic done_q, done_d, tx_q, tx_d, sw_q, sw_d, cap_q, cap_d, fs_q, fs_d;
  logic start_run, new_frame, last_frame, in_run;
  logic [CNT_W:0] cap_end;
  // Sequencing: config latch, frame counters, handshake, and next-cycle window values
  always_comb begin
    state_d     = state_q;
    fc_d        = fc_q;
    idx_d       = idx_q;
    len_d       = len_q;
    nfr_d       = nfr_q;
    txl_d       = txl_q;
    swon_d      = swon_q;
    swoff_d     = swoff_q;
    cdly_d      = cdly_q;
    clen_d      = clen_q;
    cap_ok_d    = cap_ok_q;
    stop_pend_d = stop_pend_q;
    cap_ovf_d   = cap_ovf_q;
    done_d      = 1'b0;
    start_run   = 1'b0;
    new_frame   = 1'b0;
    last_frame  = (nfr_q != '0) && (idx_q == nfr_q - IDX_W'(1));
    case (state_q)
      IDLE: if (go) begin
        len_d     = (cfg_frame_len < CNT_W'(2)) ? CNT_W'(2) : cfg_frame_len;
        nfr_d     = cfg_num_frames;
        txl_d     = cfg_tx_len;
        swon_d    = cfg_sw_on;
        swoff_d   = cfg_sw_off;
        cdly_d    = cfg_cap_dly;
        clen_d    = cfg_cap_len;
        cap_ovf_d = 1'b0;
        idx_d     = '0;
        state_d   = cfg_use_trig ? ARM : IDLE;
        start_run = ~cfg_use_trig;
      end
      ARM: if (stop) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else if (ext_trig && !trig_d_q) begin
        start_run = 1'b1;
      end
      RUN: begin
        stop_pend_d = stop_pend_q | stop;
        if (fc_q == len_q - CNT_W'(1)) begin
          if (last_frame || stop_pend_q || stop) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            fc_d      = '0;
            idx_d     = idx_q + IDX_W'(1);
            new_frame = 1'b1;
          end
        end else begin
          fc_d = fc_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (start_run) begin
      state_d     = RUN;
      fc_d        = '0;
      idx_d       = '0;
      stop_pend_d = 1'b0;
      new_frame   = 1'b1;
    end
    if (new_frame) begin
      cap_ok_d  = cap_ready;
      cap_ovf_d = cap_ovf_d | ~cap_ready;
    end
    in_run  = (state_d == RUN);
    cap_end = {1'b0, cdly_d} + {1'b0, clen_d};
    tx_d    = in_run && (fc_d < txl_d);
    sw_d    = in_run && (fc_d >= swon_d) && (fc_d < swoff_d);
    cap_d   = in_run && cap_ok_d && (fc_d >= cdly_d) && ({1'b0, fc_d} < cap_end);
    fs_d    = in_run && new_frame;
  end
  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      fc_q        <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      nfr_q       <= '0;
      txl_q       <= '0;
      swon_q      <= '0;
      swoff_q     <= '0;
      cdly_q      <= '0;
      clen_q      <= '0;
      cap_ok_q    <= 1'b0;
      stop_pend_q <= 1'b0;
      trig_d_q    <= 1'b0;
      cap_ovf_q   <= 1'b0;
      done_q      <= 1'b0;
      tx_q        <= 1'b0;
      sw_q        <= 1'b0;
      cap_q       <= 1'b0;
      fs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      fc_q        <= fc_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      nfr_q       <= nfr_d;
      txl_q       <= txl_d;
      swon_q      <= swon_d;
      swoff_q     <= swoff_d;
      cdly_q      <= cdly_d;
      clen_q      <= clen_d;
      cap_ok_q    <= cap_ok_d;
      stop_pend_q <= stop_pend_d;
      trig_d_q    <= ext_trig;
      cap_ovf_q   <= cap_ovf_d;
      done_q      <= done_d;
      tx_q        <= tx_d;
      sw_q        <= sw_d;
      cap_q       <= cap_d;
      fs_q        <= fs_d;
    end
  end
  assign tx_en       = tx_q;
  assign rxq_sw_ctl  = sw_q;
  assign cap_en      = cap_q;
  assign frame_start = fs_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign cap_ovf     = cap_ovf_q;
  assign frame_idx   = idx_q;
endmodule

// File: tb/tb_quanet_frame_sched.sv
// tb_quanet_frame_sched: randomized and directed checks against a timeline model
module tb_quanet_frame_sched;
  localparam int CW = 24;
  localparam int IW = 16;
  logic clk = 1'b0;
  logic rst, go, stop, ext_trig, cfg_use_trig, cap_ready;
  logic [CW-1:0] cfg_frame_len, cfg_tx_len, cfg_sw_on, cfg_sw_off, cfg_cap_dly, cfg_cap_len;
  logic [IW-1:0] cfg_num_frames;
  logic tx_en, rxq_sw_ctl, cap_en, frame_start, busy, done, cap_ovf;
  logic [IW-1:0] frame_idx;
  int checks = 0;
  int errors = 0;
  bit cr [0:4095];

  quanet_frame_sched dut (
    .clk(clk), .rst(rst), .go(go), .stop(stop), .ext_trig(ext_trig),
    .cfg_use_trig(cfg_use_trig), .cfg_frame_len(cfg_frame_len),
    .cfg_num_frames(cfg_num_frames), .cfg_tx_len(cfg_tx_len), .cfg_sw_on(cfg_sw_on),
    .cfg_sw_off(cfg_sw_off), .cfg_cap_dly(cfg_cap_dly), .cfg_cap_len(cfg_cap_len),
    .cap_ready(cap_ready), .tx_en(tx_en), .rxq_sw_ctl(rxq_sw_ctl), .cap_en(cap_en),
    .frame_start(frame_start), .busy(busy), .done(done), .cap_ovf(cap_ovf),
    .frame_idx(frame_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [22:0] outv();
    return {tx_en, rxq_sw_ctl, cap_en, frame_start, busy, done, cap_ovf, frame_idx};
  endfunction

  task automatic set_cfg(int fl, int nfr, int txl, int son, int soff, int cdly, int clen);
    cfg_frame_len  = CW'(fl);
    cfg_num_frames = IW'(nfr);
    cfg_tx_len     = CW'(txl);
    cfg_sw_on      = CW'(son);
    cfg_sw_off     = CW'(soff);
    cfg_cap_dly    = CW'(cdly);
    cfg_cap_len    = CW'(clen);
  endtask

  // Burst starting immediately; expected outputs derived from elapsed cycles since go
  task automatic run_burst(string name, int fl, int nfr, int txl, int son, int soff,
                           int cdly, int clen, int stop_k, int pct, int low_k);
    int L, nf, kmax, fc, f, ns;
    bit run, ovf;
    logic [22:0] exp_v;
    L = (fl < 2) ? 2 : fl;
    nf = nfr;
    if (stop_k > 0 && (nfr == 0 || stop_k <= nfr * L)) begin
      ns = (stop_k - 1) / L + 1;
      nf = (nfr == 0 || ns < nfr) ? ns : nfr;
    end
    kmax = nf * L + 3;
    for (int k = 0; k <= kmax; k++) cr[k] = (k == low_k) ? 1'b0 : ($urandom_range(99) < pct);
    @(negedge clk);
    set_cfg(fl, nfr, txl, son, soff, cdly, clen);
    cfg_use_trig = 1'b0;
    go = 1'b1;
    cap_ready = cr[0];
    @(negedge clk);
    go = 1'b0;
    for (int k = 1; k <= kmax; k++) begin
      fc = (k - 1) % L;
      f = (k - 1) / L;
      run = (k <= nf * L);
      ovf = 1'b0;
      for (int g = 0; g < nf; g++) if (g * L + 1 <= k && !cr[g * L]) ovf = 1'b1;
      if (run)
        exp_v = {fc < txl, (fc >= son) && (fc < soff),
                 cr[f * L] && (fc >= cdly) && (longint'(fc) < longint'(cdly) + longint'(clen)),
                 fc == 0, 1'b1, 1'b0, ovf, IW'(f)};
      else
        exp_v = {5'b0, k == nf * L + 1, ovf, IW'(nf - 1)};
      checks++;
      if (outv() !== exp_v) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, k, outv(), exp_v);
      end
      cap_ready = cr[k];
      stop = (k == stop_k);
      @(negedge clk);
    end
    stop = 1'b0;
    cap_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (outv() !== 23'd0) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0", outv());
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_burst("basic_tx", 10, 3, 4, 0, 0, 0, 0, 0, 100, -1);
    run_burst("windows_clip", 10, 4, 3, 2, 7, 5, 20, 0, 100, -1);
    run_burst("sw_on_ge_off", 6, 2, 10, 5, 3, 0, 6, 0, 100, -1);
  endtask

  task automatic test_cap_ovf();
    run_burst("cap_skip", 10, 3, 4, 2, 7, 1, 5, 0, 100, 10);
    repeat (3) @(negedge clk);
    checks++;
    if (cap_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_held: got %b expected 1", cap_ovf);
    end
    run_burst("ovf_cleared", 5, 2, 2, 0, 1, 0, 5, 0, 100, -1);
  endtask

  task automatic test_stop();
    run_burst("cont_stop", 8, 0, 3, 1, 4, 2, 3, 44, 100, -1);
    checks++;
    if (frame_idx !== IW'(5)) begin
      errors++;
      $display("FAIL stop_idx: got %0d expected 5", frame_idx);
    end
  endtask

  task automatic test_trig();
    int first;
    @(negedge clk);
    ext_trig = 1'b1;
    @(negedge clk);
    set_cfg(4, 1, 2, 0, 4, 0, 4);
    cfg_use_trig = 1'b1;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (busy !== 1'b1 || frame_start !== 1'b0 || tx_en !== 1'b0) begin
        errors++;
        $display("FAIL armed_wait: busy %b fs %b tx %b expected 1 0 0", busy, frame_start, tx_en);
      end
      @(negedge clk);
    end
    ext_trig = 1'b0;
    @(negedge clk);
    ext_trig = 1'b1;
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b1 || tx_en !== 1'b1 || frame_idx !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL trig_start: fs %b tx %b idx %0d busy %b expected 1 1 0 1",
               frame_start, tx_en, frame_idx, busy);
    end
    first = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (done && first < 0) first = i;
    end
    checks++;
    if (first != 4) begin
      errors++;
      $display("FAIL trig_done: done at %0d expected 4", first);
    end
    ext_trig = 1'b0;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL arm_stop: done %b busy %b fs %b expected 1 0 0", done, busy, frame_start);
    end
    cfg_use_trig = 1'b0;
  endtask

  task automatic test_rst_mid();
    @(negedge clk);
    set_cfg(10, 0, 100, 0, 100, 0, 100);
    cfg_use_trig = 1'b0;
    cap_ready = 1'b1;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (14) @(negedge clk);
    checks++;
    if (tx_en !== 1'b1 || cap_en !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst_active: tx %b cap %b expected 1 1", tx_en, cap_en);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (outv() !== 23'd0) begin
      errors++;
      $display("FAIL mid_rst: got %h expected 0", outv());
    end
    rst = 1'b0;
    run_burst("after_rst_len0", 0, 3, 1, 1, 2, 0, 1, 0, 100, -1);
    run_burst("len1", 1, 2, 5, 0, 9, 1, 9, 0, 100, -1);
  endtask

  task automatic test_random();
    int fl, L, nfr, sk;
    for (int it = 0; it < 12; it++) begin
      fl = $urandom_range(12);
      L = (fl < 2) ? 2 : fl;
      nfr = $urandom_range(4);
      if (nfr == 0) sk = $urandom_range(3 * L, 1);
      else sk = $urandom_range(1) ? $urandom_range(nfr * L, 1) : 0;
      run_burst($sformatf("rand%0d", it), fl, nfr, $urandom_range(L + 3), $urandom_range(L + 2),
                $urandom_range(L + 3), $urandom_range(L + 2), $urandom_range(L + 3), sk, 80, -1);
    end
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; stop = 1'b0; ext_trig = 1'b0; cfg_use_trig = 1'b0; cap_ready = 1'b1;
    set_cfg(0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_basic();
    test_cap_ovf();
    test_stop();
    test_trig();
    test_rst_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
